// File: rtl/ysyx_23060240_lsu_pkg.sv
// Shared LSU definitions: FSM state encoding, RV32 load/store width codes and
// the misaligned-access predicate used when LSU_MISALIGN_CHECK_EN is defined.
package ysyx_23060240_pkg;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // A half-word is only illegal when it would straddle the word boundary.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      if (funct3 == F3_H || funct3 == F3_HU) mis = (off == 2'd3);
      else if (funct3 == F3_W)               mis = (off != 2'd0);
      return mis;
   endfunction

endpackage

// File: rtl/ysyx_23060240_lsu_if.sv
// LSU bus bundle: EXU request, WBU response and SRAM port. out_misalign is
// present only when LSU_MISALIGN_CHECK_EN is defined.
interface ysyx_23060240_lsu_if;

   // Both handshakes: a transfer happens on a rising edge where valid && ready;
   // valid and its payload hold steady until that edge, and valid never waits on ready.
   logic        in_valid;
   logic        in_ready;
   logic        in_is_load;
   logic        in_is_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [31:0] in_result;
   logic [4:0]  in_rd;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
`ifdef LSU_MISALIGN_CHECK_EN
   logic        out_misalign;
`endif

   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_raddr;
   logic [31:0] mem_waddr;
   logic [7:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata,
             in_result, in_rd, out_ready, mem_rdata,
`ifdef LSU_MISALIGN_CHECK_EN
      output out_misalign,
`endif
      output in_ready, out_valid, out_data, out_rd,
             mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wmask, mem_wdata
   );

   modport master (
      output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata,
             in_result, in_rd, out_ready, mem_rdata,
`ifdef LSU_MISALIGN_CHECK_EN
      input  out_misalign,
`endif
      input  in_ready, out_valid, out_data, out_rd,
             mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wmask, mem_wdata
   );

endinterface

// File: rtl/ysyx_23060240_lsu_align.sv
// Combinational lane logic: store byte-mask/data placement and load lane
// extraction with sign/zero extension, both driven by funct3 and addr[1:0].
module ysyx_23060240_lsu_align
   import ysyx_23060240_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  wmask,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext
);

   logic [31:0] lane;

   // Mask bits shifted past bit 3 fall off the 4-bit result on purpose.
   always_comb begin
      wmask    = 4'b1111;
      wdata_sh = wdata;
      case (funct3)
         F3_B, F3_BU: begin
            wmask    = 4'b0001 << off;
            wdata_sh = wdata << {off, 3'b000};
         end
         F3_H, F3_HU: begin
            wmask    = 4'b0011 << off;
            wdata_sh = wdata << {off, 3'b000};
         end
         default: ;
      endcase
   end

   assign lane = rdata >> {off, 3'b000};

   always_comb begin
      case (funct3)
         F3_B:    rdata_ext = {{24{lane[7]}}, lane[7:0]};
         F3_BU:   rdata_ext = {24'd0, lane[7:0]};
         F3_H:    rdata_ext = {{16{lane[15]}}, lane[15:0]};
         F3_HU:   rdata_ext = {16'd0, lane[15:0]};
         default: rdata_ext = lane;
      endcase
   end

endmodule

// File: rtl/ysyx_23060240_lsu.sv
// Load/store unit: one request at a time from EXU, single-cycle SRAM access,
// result handed to WBU. Optional LSU_MISALIGN_CHECK_EN rejects misaligned H/W.
module ysyx_23060240_lsu
   import ysyx_23060240_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   ysyx_23060240_lsu_if.slave bus,
   output lsu_state_e         dbg_state
);

   lsu_state_e  state;
   lsu_state_e  state_nxt;

   logic        r_load;
   logic        r_store;
   logic [2:0]  r_f3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_data;
   logic [4:0]  r_rd;

   logic [3:0]  wmask;
   logic [31:0] wdata_sh;
   logic [31:0] rdata_ext;
   logic        accept;
   logic        acc_mis;

   assign accept = (state == LSU_IDLE) && bus.in_valid;

`ifdef LSU_MISALIGN_CHECK_EN
   logic r_mis;
   assign acc_mis = (bus.in_is_load || bus.in_is_store) &&
                    is_misaligned(bus.in_funct3, bus.in_addr[1:0]);
`else
   assign acc_mis = 1'b0;
`endif

   ysyx_23060240_lsu_align u_align (
      .funct3    (r_f3),
      .off       (r_addr[1:0]),
      .wdata     (r_wdata),
      .rdata     (bus.mem_rdata),
      .wmask     (wmask),
      .wdata_sh  (wdata_sh),
      .rdata_ext (rdata_ext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LSU_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LSU_IDLE: if (bus.in_valid) begin
            if ((bus.in_is_load || bus.in_is_store) && !acc_mis) state_nxt = LSU_REQ;
            else                                                 state_nxt = LSU_DONE;
         end
         LSU_REQ:  state_nxt = r_load ? LSU_WAIT : LSU_DONE;
         LSU_WAIT: state_nxt = LSU_DONE;
         LSU_DONE: if (bus.out_ready) state_nxt = LSU_IDLE;
         default:  state_nxt = LSU_IDLE;
      endcase
   end

   // Everything on the SRAM side is decoded from state and latched fields only.
   always_comb begin
      bus.in_ready  = (state == LSU_IDLE);
      bus.out_valid = (state == LSU_DONE);
      bus.out_data  = r_data;
      bus.out_rd    = r_rd;
      bus.mem_ren   = (state == LSU_REQ) && r_load;
      bus.mem_wen   = (state == LSU_REQ) && r_store;
      bus.mem_raddr = bus.mem_ren ? {r_addr[31:2], 2'b00} : 32'd0;
      bus.mem_waddr = bus.mem_wen ? {r_addr[31:2], 2'b00} : 32'd0;
      bus.mem_wmask = bus.mem_wen ? {4'b0000, wmask} : 8'd0;
      bus.mem_wdata = bus.mem_wen ? wdata_sh : 32'd0;
`ifdef LSU_MISALIGN_CHECK_EN
      bus.out_misalign = r_mis;
`endif
   end

   // Pass-through and rejected requests get their result at accept; loads overwrite it in WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_load  <= 1'b0;
         r_store <= 1'b0;
         r_f3    <= 3'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_data  <= 32'd0;
         r_rd    <= 5'd0;
`ifdef LSU_MISALIGN_CHECK_EN
         r_mis   <= 1'b0;
`endif
      end else if (accept) begin
         r_load  <= bus.in_is_load;
         r_store <= bus.in_is_store;
         r_f3    <= bus.in_funct3;
         r_addr  <= bus.in_addr;
         r_wdata <= bus.in_wdata;
         r_data  <= acc_mis ? 32'd0 : bus.in_result;
         r_rd    <= bus.in_rd;
`ifdef LSU_MISALIGN_CHECK_EN
         r_mis   <= acc_mis;
`endif
      end else if (state == LSU_WAIT) begin
         r_data  <= rdata_ext;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_ysyx_23060240_lsu.sv
// Bench for ysyx_23060240_lsu: byte-level reference model of SRAM and lane
// rules, directed cases plus randomized traffic. Honours LSU_MISALIGN_CHECK_EN.
`timescale 1ns/1ps
module tb_ysyx_23060240_lsu;
   import ysyx_23060240_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   lsu_state_e dbg_state;

   ysyx_23060240_lsu_if bus();

   ysyx_23060240_lsu dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] sram    [16];
   logic [31:0] ref_mem [16];
   logic        pre_we = 1'b0;
   logic [3:0]  pre_idx = 4'd0;
   logic [31:0] pre_data = 32'd0;

   // SRAM model: read data registered one cycle after mem_ren, 0 otherwise.
   always @(posedge clk) begin
      if (bus.mem_ren) bus.mem_rdata <= sram[bus.mem_raddr[5:2]];
      else             bus.mem_rdata <= 32'd0;
      if (bus.mem_wen)
         for (int b = 0; b < 4; b++)
            if (bus.mem_wmask[b]) sram[bus.mem_waddr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      if (pre_we) sram[pre_idx] <= pre_data;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int nbytes(input logic [2:0] f3);
      if (f3 == F3_B || f3 == F3_BU) return 1;
      if (f3 == F3_H || f3 == F3_HU) return 2;
      return 4;
   endfunction

   function automatic logic model_mis(input logic [2:0] f3, input logic [1:0] off);
      int n;
      n = nbytes(f3);
      return (n == 2 && off == 2'd3) || (n == 4 && off != 2'd0);
   endfunction

   // Bytes that would land past the word boundary are simply dropped.
   function automatic void model_store(input logic [2:0] f3, input logic [1:0] off,
                                       input logic [31:0] wd, output logic [3:0] m,
                                       output logic [31:0] d);
      int n;
      n = nbytes(f3);
      m = 4'd0;
      d = 32'd0;
      if (n == 4) begin
         m = 4'hF;
         d = wd;
      end else begin
         for (int i = 0; i < n; i++)
            if (int'(off) + i < 4) begin
               m[int'(off) + i] = 1'b1;
               d[8*(int'(off) + i) +: 8] = wd[8*i +: 8];
            end
      end
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
      logic [7:0] b [4];
      for (int i = 0; i < 4; i++)
         b[i] = (int'(off) + i < 4) ? word[8*(int'(off) + i) +: 8] : 8'h00;
      case (f3)
         F3_B:    return {{24{b[0][7]}}, b[0]};
         F3_BU:   return {24'd0, b[0]};
         F3_H:    return {{16{b[1][7]}}, b[1], b[0]};
         F3_HU:   return {16'd0, b[1], b[0]};
         default: return {b[3], b[2], b[1], b[0]};
      endcase
   endfunction

   task automatic preload(input int idx, input logic [31:0] val);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = idx[3:0];
      pre_data = val;
      @(posedge clk);
      #1 pre_we = 1'b0;
      ref_mem[idx] = val;
   endtask

   task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] res, input logic [4:0] rd, input int hold);
      int          lat_exp, vcyc, ren_cnt, wen_cnt, widx, k;
      logic        mis, has_exp;
      logic [3:0]  em;
      logic [31:0] ed, bm, got, held;
      widx    = int'(addr[5:2]);
      mis     = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      mis     = (ld || st) && model_mis(f3, addr[1:0]);
`endif
      lat_exp = (mis || !(ld || st)) ? 1 : (ld ? 3 : 2);
      model_store(f3, addr[1:0], wd, em, ed);
      bm      = {{8{em[3]}}, {8{em[2]}}, {8{em[1]}}, {8{em[0]}}};
      has_exp = 1'b1;
      if (mis)     exp_q.push_back(32'd0);
      else if (ld) exp_q.push_back(model_load(f3, addr[1:0], ref_mem[widx]));
      else if (st) has_exp = 1'b0;
      else         exp_q.push_back(res);
      if (st && !mis)
         for (int i = 0; i < 4; i++)
            if (em[i]) ref_mem[widx][8*i +: 8] = ed[8*i +: 8];

      @(negedge clk);
      k = 0;
      while (!bus.in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL in_ready_wait: in_ready=%b required 1", bus.in_ready);
      end
      bus.in_valid    = 1'b1;
      bus.in_is_load  = ld;
      bus.in_is_store = st;
      bus.in_funct3   = f3;
      bus.in_addr     = addr;
      bus.in_wdata    = wd;
      bus.in_result   = res;
      bus.in_rd       = rd;
      @(posedge clk);
      #1;
      bus.in_valid    = 1'b0;
      bus.in_is_load  = $urandom_range(0, 1);
      bus.in_is_store = $urandom_range(0, 1);
      bus.in_funct3   = 3'($urandom_range(0, 7));
      bus.in_addr     = $urandom;
      bus.in_wdata    = $urandom;
      bus.in_result   = $urandom;
      bus.in_rd       = 5'($urandom_range(0, 31));

      vcyc = -1; ren_cnt = 0; wen_cnt = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (bus.mem_ren) begin
            ren_cnt++;
            checks++;
            if (bus.mem_raddr !== {addr[31:2], 2'b00} || c != 1) begin
               errors++;
               $display("FAIL load_req: raddr=%h cycle=%0d required %h cycle 1",
                        bus.mem_raddr, c, {addr[31:2], 2'b00});
            end
         end
         if (bus.mem_wen) begin
            wen_cnt++;
            checks++;
            if (bus.mem_waddr !== {addr[31:2], 2'b00} || bus.mem_wmask !== {4'd0, em} ||
                (bus.mem_wdata & bm) !== ed || c != 1) begin
               errors++;
               $display("FAIL store_req: waddr=%h mask=%h wdata=%h cycle=%0d required %h %h %h(masked) cycle 1",
                        bus.mem_waddr, bus.mem_wmask, bus.mem_wdata, c,
                        {addr[31:2], 2'b00}, {4'd0, em}, ed);
            end
         end
         checks++;
         if ((!bus.mem_ren && bus.mem_raddr !== 32'd0) ||
             (!bus.mem_wen && (bus.mem_waddr !== 32'd0 || bus.mem_wmask !== 8'd0 ||
                               bus.mem_wdata !== 32'd0))) begin
            errors++;
            $display("FAIL mem_quiet: raddr=%h waddr=%h mask=%h wdata=%h required 0",
                     bus.mem_raddr, bus.mem_waddr, bus.mem_wmask, bus.mem_wdata);
         end
         if (bus.out_valid) begin
            vcyc = c;
            break;
         end
      end

      checks++;
      if (vcyc != lat_exp) begin
         errors++;
         $display("FAIL out_latency: out_valid at T+%0d required T+%0d", vcyc, lat_exp);
      end
      checks++;
      if (ren_cnt != int'(ld && !mis) || wen_cnt != int'(st && !mis)) begin
         errors++;
         $display("FAIL mem_pulses: ren=%0d wen=%0d required %0d %0d",
                  ren_cnt, wen_cnt, int'(ld && !mis), int'(st && !mis));
      end
      checks++;
      if (bus.out_rd !== rd) begin
         errors++;
         $display("FAIL out_rd: got %0d required %0d", bus.out_rd, rd);
      end
      if (has_exp) begin
         got = exp_q.pop_front();
         checks++;
         if (bus.out_data !== got) begin
            errors++;
            $display("FAIL out_data: got %h required %h", bus.out_data, got);
         end
      end
`ifdef LSU_MISALIGN_CHECK_EN
      checks++;
      if (bus.out_misalign !== mis) begin
         errors++;
         $display("FAIL out_misalign: got %b required %b", bus.out_misalign, mis);
      end
`endif
      held = bus.out_data;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== held ||
             bus.out_rd !== rd) begin
            errors++;
            $display("FAIL backpressure_hold: valid=%b in_ready=%b data=%h rd=%0d required 1 0 %h %0d",
                     bus.out_valid, bus.in_ready, bus.out_data, bus.out_rd, held, rd);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL handshake_return: out_valid=%b in_ready=%b required 0 1",
                  bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_is_load = 1'b0; bus.in_is_store = 1'b0;
      bus.in_funct3 = 3'd0; bus.in_addr = 32'd0; bus.in_wdata = 32'd0;
      bus.in_result = 32'd0; bus.in_rd = 5'd0; bus.out_ready = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 16; i++) preload(i, $urandom);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || dbg_state !== LSU_IDLE) begin
         errors++;
         $display("FAIL reset_ctrl: in_ready=%b out_valid=%b state=%0d required 1 0 0",
                  bus.in_ready, bus.out_valid, dbg_state);
      end
      checks++;
      if (bus.out_data !== 32'd0 || bus.out_rd !== 5'd0 || bus.mem_ren !== 1'b0 ||
          bus.mem_wen !== 1'b0 || bus.mem_wmask !== 8'd0 || bus.mem_wdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs: data=%h rd=%0d ren=%b wen=%b mask=%h wdata=%h required all 0",
                  bus.out_data, bus.out_rd, bus.mem_ren, bus.mem_wen, bus.mem_wmask, bus.mem_wdata);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_sw();
      do_op(1'b0, 1'b1, F3_W, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 5'd3, 0);
      checks++;
      if (sram[1] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL sw_memory: got %h required deadbeef", sram[1]);
      end
   endtask

   task automatic test_sb();
      do_op(1'b0, 1'b1, F3_B, 32'h8000_0003, 32'h0000_00A5, 32'h0, 5'd4, 0);
      checks++;
      if (sram[0][31:24] !== 8'hA5) begin
         errors++;
         $display("FAIL sb_memory: top byte %h required a5", sram[0][31:24]);
      end
   endtask

   task automatic test_lb_lbu();
      preload(0, 32'h1280_FF34);
      do_op(1'b1, 1'b0, F3_B,  32'h8000_0002, 32'h0, 32'h0, 5'd5, 0);
      do_op(1'b1, 1'b0, F3_BU, 32'h8000_0002, 32'h0, 32'h0, 5'd6, 0);
   endtask

   task automatic test_backpressure();
      preload(2, 32'h8001_0000);
      do_op(1'b1, 1'b0, F3_H, 32'h8000_000A, 32'h0, 32'h0, 5'd7, 5);
      do_op(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 32'h1357_9BDF, 5'd8, 3);
   endtask

   task automatic test_reset_during_store();
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_is_load = 1'b0; bus.in_is_store = 1'b1;
      bus.in_funct3 = F3_W; bus.in_addr = 32'h8000_000C; bus.in_wdata = 32'h1234_5678;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      checks++;
      if (bus.mem_wen !== 1'b1) begin
         errors++;
         $display("FAIL rst_store_req: mem_wen=%b required 1", bus.mem_wen);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.mem_wen !== 1'b0 || dbg_state !== LSU_IDLE || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_store_async: wen=%b state=%0d in_ready=%b required 0 0 1",
                  bus.mem_wen, dbg_state, bus.in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || dbg_state !== LSU_IDLE ||
          sram[3] !== ref_mem[3]) begin
         errors++;
         $display("FAIL rst_store_after: in_ready=%b out_valid=%b state=%0d mem=%h required 1 0 0 %h",
                  bus.in_ready, bus.out_valid, dbg_state, sram[3], ref_mem[3]);
      end
   endtask

`ifdef LSU_MISALIGN_CHECK_EN
   task automatic test_misalign();
      do_op(1'b1, 1'b0, F3_W, 32'h8000_0001, 32'h0, 32'hFFFF_FFFF, 5'd9, 0);
      do_op(1'b0, 1'b1, F3_H, 32'h8000_0007, 32'hAAAA_5555, 32'h0, 5'd10, 0);
   endtask
`endif

   task automatic test_random(input int n);
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          kind;
      for (int i = 0; i < n; i++) begin
         kind = $urandom_range(0, 2);
         ld   = (kind == 0);
         st   = (kind == 1);
         addr = 32'h8000_0000 | 32'($urandom_range(0, 63));
         if (st) begin
            case ($urandom_range(0, 2))
               0:       f3 = F3_B;
               1:       f3 = F3_H;
               default: f3 = F3_W;
            endcase
`ifndef LSU_MISALIGN_CHECK_EN
            if (f3 == F3_W) addr[1:0] = 2'b00;
`endif
         end else begin
            case ($urandom_range(0, 4))
               0:       f3 = F3_B;
               1:       f3 = F3_H;
               2:       f3 = F3_W;
               3:       f3 = F3_BU;
               default: f3 = F3_HU;
            endcase
         end
         do_op(ld, st, f3, addr, $urandom, $urandom, 5'($urandom_range(0, 31)),
               $urandom_range(0, 2));
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (sram[i] !== ref_mem[i]) begin
            errors++;
            $display("FAIL final_memory[%0d]: got %h required %h", i, sram[i], ref_mem[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_sb();
      test_lb_lbu();
      test_backpressure();
      test_reset_during_store();
`ifdef LSU_MISALIGN_CHECK_EN
      test_misalign();
`endif
      test_random(150);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
